// File: rtl/spi_rx_monitor.sv
// SPI receive monitor: oversamples sck/sdi on the system clock, deserializes
// MSB-first bytes into an RX FIFO and exposes FIFO, status and control on the device bus.
module spi_rx_monitor #(
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int FifoDepth   = 8,
    parameter int IdleTimeout = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sck_i,
    input  logic        sdi_i,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    output logic        byte_valid_o,
    output logic [7:0]  byte_o,
    output logic        irq_o
);
    localparam int AW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int LW = AW + 1;
    localparam int IW = $clog2(IdleTimeout + 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IdleTimeout);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FifoDepth);
    localparam bit SAMPLE_RISE = (CPOL == CPHA);

    localparam logic [11:0] ADDR_RX_DATA = 12'h000;
    localparam logic [11:0] ADDR_STATUS  = 12'h004;
    localparam logic [11:0] ADDR_CTRL    = 12'h008;

    logic          r_sck_s1, r_sck_s2, r_sck_prev;
    logic          r_sdi_s1, r_sdi_s2;
    logic [7:0]    r_shift;
    logic [3:0]    r_bit_cnt;
    logic [IW-1:0] r_idle_cnt;
    logic [7:0]    r_mem [FifoDepth];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow, r_frame_err, r_enable;
    logic [7:0]    r_byte;
    logic          r_byte_valid, r_irq, r_rvalid;
    logic [31:0]   r_rdata;

    logic          w_sample_edge, w_take, w_byte_done, w_timeout;
    logic [7:0]    w_shift_nxt;
    logic [11:0]   w_addr;
    logic          w_rd, w_wr_ctrl, w_flush, w_clr;
    logic          w_empty, w_full, w_pop, w_push_ok, w_push_drop;
    logic [3:0]    w_bit_cnt_nxt;
    logic [IW-1:0] w_idle_nxt;
    logic [LW-1:0] w_level_nxt;
    logic          w_overflow_nxt, w_frame_err_nxt;
    logic [31:0]   w_rdata_nxt;
    logic          w_unused_bits;

    assign w_unused_bits = ^{device_be_i, device_addr_i[31:12], device_wdata_i[31:3]};

    assign w_sample_edge = SAMPLE_RISE ? (r_sck_s2 & ~r_sck_prev) : (~r_sck_s2 & r_sck_prev);
    assign w_take        = w_sample_edge & r_enable;
    assign w_byte_done   = w_take & (r_bit_cnt == 4'd7);
    assign w_shift_nxt   = {r_shift[6:0], r_sdi_s2};
    assign w_timeout     = r_enable & ~w_take & (r_idle_cnt == IDLE_MAX) & (r_bit_cnt != 4'd0);

    assign w_addr      = device_addr_i[11:0];
    assign w_rd        = device_req_i & ~device_we_i;
    assign w_wr_ctrl   = device_req_i & device_we_i & (w_addr == ADDR_CTRL);
    assign w_flush     = w_wr_ctrl & device_wdata_i[0];
    assign w_clr       = w_wr_ctrl & device_wdata_i[1];
    assign w_empty     = (r_level == {LW{1'b0}});
    assign w_full      = (r_level == LEVEL_FULL);
    assign w_pop       = w_rd & (w_addr == ADDR_RX_DATA) & ~w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok   = w_byte_done & ~w_flush & (~w_full | w_pop);
    assign w_push_drop = w_byte_done & ~w_flush & w_full & ~w_pop;

    // Bit counter, idle counter and sticky error flag next-state.
    always_comb begin
        w_bit_cnt_nxt   = r_bit_cnt;
        w_idle_nxt      = r_idle_cnt;
        w_frame_err_nxt = r_frame_err;
        w_overflow_nxt  = r_overflow;
        if (w_sample_edge) begin
            w_idle_nxt = {IW{1'b0}};
        end else if (r_idle_cnt != IDLE_MAX) begin
            w_idle_nxt = r_idle_cnt + {{(IW-1){1'b0}}, 1'b1};
        end else begin
            w_idle_nxt = r_idle_cnt;
        end
        if (!r_enable) begin
            w_bit_cnt_nxt = 4'd0;
        end else if (w_take) begin
            w_bit_cnt_nxt = w_byte_done ? 4'd0 : (r_bit_cnt + 4'd1);
        end else if (w_timeout) begin
            w_bit_cnt_nxt = 4'd0;
        end else begin
            w_bit_cnt_nxt = r_bit_cnt;
        end
        if (w_clr) begin
            w_frame_err_nxt = 1'b0;
            w_overflow_nxt  = 1'b0;
        end else begin
            w_frame_err_nxt = r_frame_err;
            w_overflow_nxt  = r_overflow;
        end
        if (w_timeout) begin
            w_frame_err_nxt = 1'b1;
        end else begin
            w_frame_err_nxt = w_frame_err_nxt;
        end
        if (w_push_drop) begin
            w_overflow_nxt = 1'b1;
        end else begin
            w_overflow_nxt = w_overflow_nxt;
        end
    end

    // FIFO occupancy next-state.
    always_comb begin
        w_level_nxt = r_level;
        if (w_flush) begin
            w_level_nxt = {LW{1'b0}};
        end else begin
            w_level_nxt = r_level + LW'(w_push_ok) - LW'(w_pop);
        end
    end

    // Read data mux for the registered bus response.
    always_comb begin
        w_rdata_nxt = 32'd0;
        if (w_rd) begin
            case (w_addr)
                ADDR_RX_DATA: w_rdata_nxt = w_empty ? 32'd0 : {1'b1, 23'd0, r_mem[r_rd_ptr]};
                ADDR_STATUS:  w_rdata_nxt = {8'd0, 4'd0, r_bit_cnt, 8'(r_level), 4'd0,
                                             r_frame_err, r_overflow, w_full, w_empty};
                ADDR_CTRL:    w_rdata_nxt = {29'd0, r_enable, 2'b00};
                default:      w_rdata_nxt = 32'd0;
            endcase
        end else begin
            w_rdata_nxt = 32'd0;
        end
    end

    // Storage array is left unreset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_shift_nxt;
        end
    end

    // Synchronizers, deserializer, FIFO pointers, control and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sck_s1     <= CPOL;
            r_sck_s2     <= CPOL;
            r_sck_prev   <= CPOL;
            r_sdi_s1     <= 1'b0;
            r_sdi_s2     <= 1'b0;
            r_shift      <= 8'd0;
            r_bit_cnt    <= 4'd0;
            r_idle_cnt   <= {IW{1'b0}};
            r_wr_ptr     <= {AW{1'b0}};
            r_rd_ptr     <= {AW{1'b0}};
            r_level      <= {LW{1'b0}};
            r_overflow   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_enable     <= 1'b1;
            r_byte       <= 8'd0;
            r_byte_valid <= 1'b0;
            r_irq        <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= 32'd0;
        end else begin
            r_sck_s1     <= sck_i;
            r_sck_s2     <= r_sck_s1;
            r_sck_prev   <= r_sck_s2;
            r_sdi_s1     <= sdi_i;
            r_sdi_s2     <= r_sdi_s1;
            r_shift      <= w_take ? w_shift_nxt : r_shift;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_idle_cnt   <= w_idle_nxt;
            r_byte       <= w_byte_done ? w_shift_nxt : r_byte;
            r_byte_valid <= w_byte_done;
            if (w_flush) begin
                r_wr_ptr <= {AW{1'b0}};
                r_rd_ptr <= {AW{1'b0}};
            end else begin
                r_wr_ptr <= w_push_ok ? (r_wr_ptr + {{(AW-1){1'b0}}, 1'b1}) : r_wr_ptr;
                r_rd_ptr <= w_pop ? (r_rd_ptr + {{(AW-1){1'b0}}, 1'b1}) : r_rd_ptr;
            end
            r_level      <= w_level_nxt;
            r_overflow   <= w_overflow_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_enable     <= w_wr_ctrl ? device_wdata_i[2] : r_enable;
            r_irq        <= (w_level_nxt != {LW{1'b0}}) | w_overflow_nxt | w_frame_err_nxt;
            r_rvalid     <= device_req_i;
            r_rdata      <= w_rdata_nxt;
        end
    end

    assign device_rvalid_o = r_rvalid;
    assign device_rdata_o  = r_rdata;
    assign byte_valid_o    = r_byte_valid;
    assign byte_o          = r_byte;
    assign irq_o           = r_irq;
endmodule

// File: tb/tb_spi_rx_monitor.sv
// Bench for spi_rx_monitor: register vector table, directed corner sequences
// and a randomized phase checked against a queue-based model of the receiver.
module tb_spi_rx_monitor;
    localparam logic [11:0] A_RX = 12'h000;
    localparam logic [11:0] A_ST = 12'h004;
    localparam logic [11:0] A_CT = 12'h008;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Mode-0 instance
    logic sck = 1'b0, sdi = 1'b0, req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic rvalid, bvalid, irq;
    logic [31:0] rdata;
    logic [7:0] bout;

    // CPOL=1/CPHA=1 instance
    logic sck3 = 1'b1, sdi3 = 1'b0, req3 = 1'b0;
    logic [31:0] addr3 = 32'd0;
    logic rvalid3, bvalid3, irq3;
    logic [31:0] rdata3;
    logic [7:0] bout3;

    spi_rx_monitor #(.CPOL(1'b0), .CPHA(1'b0), .FifoDepth(8), .IdleTimeout(64)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .sdi_i(sdi),
        .device_req_i(req), .device_addr_i(addr), .device_we_i(we), .device_be_i(4'hF),
        .device_wdata_i(wdata), .device_rvalid_o(rvalid), .device_rdata_o(rdata),
        .byte_valid_o(bvalid), .byte_o(bout), .irq_o(irq));

    spi_rx_monitor #(.CPOL(1'b1), .CPHA(1'b1), .FifoDepth(8), .IdleTimeout(64)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .sck_i(sck3), .sdi_i(sdi3),
        .device_req_i(req3), .device_addr_i(addr3), .device_we_i(1'b0), .device_be_i(4'hF),
        .device_wdata_i(32'd0), .device_rvalid_o(rvalid3), .device_rdata_o(rdata3),
        .byte_valid_o(bvalid3), .byte_o(bout3), .irq_o(irq3));

    int n_cmp = 0;
    int n_err = 0;
    int n_bv = 0;

    // reference model state
    logic [7:0] mq[$];
    bit m_ovf = 1'b0;
    bit m_ferr = 1'b0;

    always @(posedge clk) if (bvalid) n_bv++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        rd = rdata;
        chk("rvalid", {31'd0, rvalid}, 32'd1);
    endtask

    // Sends the top n bits of val (mode 0). If pop_last, an RX_DATA read is
    // placed in exactly the cycle where the final bit's push happens.
    task automatic send_bits(input logic [7:0] val, input int n, input bit pop_last,
                             output logic [31:0] rd);
        rd = 32'd0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); sdi = val[7-i];
            repeat (3) @(negedge clk);
            sck = 1'b1;
            if (pop_last && i == n - 1) begin
                @(negedge clk);
                @(negedge clk); req = 1'b1; we = 1'b0; addr = {20'd0, A_RX};
                @(negedge clk); req = 1'b0; rd = rdata;
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            sck = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] val);
        logic [31:0] d;
        send_bits(val, 8, 1'b0, d);
    endtask

    function automatic logic [31:0] model_status(input int bitcnt);
        logic [31:0] s;
        s = 32'd0;
        s[0] = (mq.size() == 0);
        s[1] = (mq.size() == 8);
        s[2] = m_ovf;
        s[3] = m_ferr;
        s[15:8] = 8'(mq.size());
        s[23:16] = 8'(bitcnt);
        return s;
    endfunction

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] wd;
        bit          check;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int          bv0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_byte", {24'd0, bout}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // register vector table
        vt.push_back('{1'b0, 32'h0000_0004, 32'd0, 1'b1, 32'h0000_0001});
        vt.push_back('{1'b0, 32'h0000_0000, 32'd0, 1'b1, 32'h0000_0000});
        vt.push_back('{1'b0, 32'h0000_0008, 32'd0, 1'b1, 32'h0000_0004});
        vt.push_back('{1'b0, 32'h0000_000C, 32'd0, 1'b1, 32'h0000_0000});
        vt.push_back('{1'b1, 32'h0000_0000, 32'hFF, 1'b0, 32'h0});
        vt.push_back('{1'b0, 32'hABCD_1004, 32'd0, 1'b1, 32'h0000_0001});
        vt.push_back('{1'b1, 32'h0000_0008, 32'h0, 1'b0, 32'h0});
        vt.push_back('{1'b0, 32'h0000_0008, 32'd0, 1'b1, 32'h0000_0000});
        vt.push_back('{1'b1, 32'h0000_0008, 32'h4, 1'b0, 32'h0});
        vt.push_back('{1'b0, 32'h0000_0008, 32'd0, 1'b1, 32'h0000_0004});
        foreach (vt[i]) begin
            bus(vt[i].w, vt[i].a, vt[i].wd, d);
            if (vt[i].check) chk($sformatf("vec%0d", i), d, vt[i].exp);
        end

        // disabled receiver ignores edges
        bus(1'b1, {20'd0, A_CT}, 32'h0, d);
        bv0 = n_bv;
        send_byte(8'hC3);
        chk("dis_bv", n_bv - bv0, 32'd0);
        bus(1'b0, {20'd0, A_ST}, 32'd0, d);
        chk("dis_status", d, 32'h0000_0001);
        bus(1'b1, {20'd0, A_CT}, 32'h4, d);

        // loopback 0xA5, 0x3C
        bv0 = n_bv;
        send_byte(8'hA5);
        chk("byte_o_a5", {24'd0, bout}, 32'h0000_00A5);
        send_byte(8'h3C);
        chk("bv_two", n_bv - bv0, 32'd2);
        bus(1'b0, {20'd0, A_RX}, 32'd0, d); chk("rx_a5", d, 32'h8000_00A5);
        bus(1'b0, {20'd0, A_RX}, 32'd0, d); chk("rx_3c", d, 32'h8000_003C);
        bus(1'b0, {20'd0, A_RX}, 32'd0, d); chk("rx_empty", d, 32'h0);
        bus(1'b0, {20'd0, A_ST}, 32'd0, d); chk("st_empty", d, 32'h0000_0001);

        // CPOL=1 CPHA=1 instance receives 0x81
        b = 8'h81;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); sck3 = 1'b0; sdi3 = b[7-i];
            repeat (4) @(negedge clk); sck3 = 1'b1;
            repeat (4) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("m3_byte", {24'd0, bout3}, 32'h0000_0081);
        @(negedge clk); req3 = 1'b1; addr3 = {20'd0, A_RX};
        @(negedge clk); req3 = 1'b0;
        chk("m3_rvalid", {31'd0, rvalid3}, 32'd1);
        chk("m3_rx", rdata3, 32'h8000_0081);

        // overflow with 9 bytes
        for (int i = 0; i < 9; i++) send_byte(8'(i));
        bus(1'b0, {20'd0, A_ST}, 32'd0, d); chk("ovf_status", d, 32'h0000_0806);
        chk("ovf_irq", {31'd0, irq}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            bus(1'b0, {20'd0, A_RX}, 32'd0, d);
            chk($sformatf("ovf_rx%0d", i), d, 32'h8000_0000 | 32'(i));
        end
        bus(1'b0, {20'd0, A_RX}, 32'd0, d); chk("ovf_lost", d, 32'h0);
        bus(1'b1, {20'd0, A_CT}, 32'h6, d);
        bus(1'b0, {20'd0, A_ST}, 32'd0, d); chk("ovf_clr", d, 32'h0000_0001);
        chk("ovf_irq_clr", {31'd0, irq}, 32'd0);

        // idle timeout after 3 bits
        send_bits(8'hE0, 3, 1'b0, d);
        bus(1'b0, {20'd0, A_ST}, 32'd0, d); chk("to_partial", d, 32'h0003_0001);
        repeat (80) @(negedge clk);
        bus(1'b0, {20'd0, A_ST}, 32'd0, d); chk("to_ferr", d, 32'h0000_0009);
        chk("to_irq", {31'd0, irq}, 32'd1);
        send_byte(8'h5A);
        bus(1'b0, {20'd0, A_RX}, 32'd0, d); chk("to_rx5a", d, 32'h8000_005A);
        bus(1'b1, {20'd0, A_CT}, 32'h6, d);

        // pop and push in the same cycle on a full FIFO
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
        send_bits(8'h18, 8, 1'b1, d);
        chk("pp_rx10", d, 32'h8000_0010);
        bus(1'b0, {20'd0, A_ST}, 32'd0, d); chk("pp_status", d, 32'h0000_0802);
        for (int i = 1; i <= 8; i++) begin
            bus(1'b0, {20'd0, A_RX}, 32'd0, d);
            chk($sformatf("pp_rx%0d", i), d, 32'h8000_0010 + 32'(i));
        end

        // reset mid-byte
        send_byte(8'h77);
        send_bits(8'hA8, 5, 1'b0, d);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mr_rdata", rdata, 32'd0);
        chk("mr_byte", {24'd0, bout}, 32'd0);
        chk("mr_irq", {31'd0, irq}, 32'd0);
        chk("mr_rvalid", {31'd0, rvalid}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus(1'b0, {20'd0, A_ST}, 32'd0, d); chk("mr_status", d, 32'h0000_0001);
        send_byte(8'hFF);
        bus(1'b0, {20'd0, A_RX}, 32'd0, d); chk("mr_rxff", d, 32'h8000_00FF);

        // randomized traffic against the queue model
        mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
        bus(1'b1, {20'd0, A_CT}, 32'h7, d);
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    b = 8'($urandom);
                    send_byte(b);
                    if (mq.size() < 8) mq.push_back(b); else m_ovf = 1'b1;
                    chk("rnd_byte", {24'd0, bout}, {24'd0, b});
                end
                3: begin
                    bus(1'b0, {20'd0, A_RX}, 32'd0, d);
                    if (mq.size() != 0) chk("rnd_rx", d, {1'b1, 23'd0, mq.pop_front()});
                    else chk("rnd_rx", d, 32'd0);
                end
                4: begin
                    bus(1'b0, {20'd0, A_ST}, 32'd0, d);
                    chk("rnd_status", d, model_status(0));
                end
                default: begin
                    bus(1'b1, {20'd0, A_CT}, 32'h6, d);
                    m_ovf = 1'b0; m_ferr = 1'b0;
                end
            endcase
            chk("rnd_irq", {31'd0, irq}, {31'd0, (mq.size() != 0) | m_ovf | m_ferr});
        end
        bus(1'b0, {20'd0, A_ST}, 32'd0, d);
        chk("rnd_final", d, model_status(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
